// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller slice.
//   - OPW        : opcode width
//   - DEF_DW     : default operand width
//   - DEF_DEPTH  : default request FIFO depth
//   - ADD        : opcode for addition
//   - state_t    : issue FSM states
package alu_pkg;

  localparam int OPW       = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 4;

  localparam logic [OPW-1:0] ADD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: request FIFO feeding the issue FSM.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write request (ignored while full)
//   pop, rdata   : read request (ignored while empty); rdata shows the head
//   full, empty  : occupancy flags
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  // A push while full is refused even if a pop happens on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests, issues them one at a time to an
// external combinational ALU and holds each result until it is consumed.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready/in_a/in_b/in_sel : request input (valid/ready)
//   alu_a/alu_b/alu_sel              : registered operands to the external ALU
//   alu_result                       : ALU result, sampled one cycle after issue
//   out_valid/out_ready/out_result/out_sel/out_carry : result output
//   op_count                         : results accepted downstream (wraps)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic [OPW-1:0] in_sel,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_sel,
  input  logic [DW:0]    alu_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW:0]    out_result,
  output logic [OPW-1:0] out_sel,
  output logic           out_carry,
  output logic [15:0]    op_count
);

  localparam int RW = OPW + 2*DW;

  state_t         state;
  logic           full, empty, pop;
  logic [RW-1:0]  head;
  logic [DW-1:0]  head_a, head_b;
  logic [OPW-1:0] head_sel;

  assign in_ready = ~full;
  assign {head_sel, head_a, head_b} = head;

  // Pop whenever the FSM is free to issue: from IDLE, or from RESP on the
  // edge the current result is accepted (keeps one result per two cycles).
  assign pop = ~empty & ((state == IDLE) | ((state == RESP) & out_ready));

  alu_req_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid & in_ready),
    .wdata ({in_sel, in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_carry = out_result[DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_sel    <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_sel;
            state   <= EXEC;
          end
        end
        // ALU operands have settled for a full cycle; capture its result.
        EXEC: begin
          out_result <= alu_result;
          out_sel    <= alu_sel;
          out_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            if (!empty) begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_sel <= head_sel;
              state   <= EXEC;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [3:0]    in_sel = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_sel;
  logic [DW:0]   alu_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW:0]   out_result;
  logic [3:0]    out_sel;
  logic          out_carry;
  logic [15:0]   op_count;

  always #5 clk = ~clk;

  // Reference ALU: used both as the external ALU and to predict results.
  function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  alu_issue_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sel(out_sel), .out_carry(out_carry), .op_count(op_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected {sel, result} in push order, plus accepted-result count.
  logic [DW+4:0] exp_q[$];
  logic [DW+4:0] e;
  int            exp_cnt = 0;
  bit            mon_en = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW:0]   prev_res;
  logic [3:0]    prev_sel;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt   = 0;
      hold_prev = 1'b0;
    end else if (mon_en) begin
      check("op_count", op_count, exp_cnt[15:0]);
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, prev_res);
        check("hold_sel", out_sel, prev_sel);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_result", out_result, e[DW:0]);
          check("sb_sel", out_sel, e[DW+4:DW+1]);
          check("sb_carry", out_carry, e[DW]);
        end
        exp_cnt = (exp_cnt + 1) & 32'hFFFF;
      end
      hold_prev = out_valid && !out_ready;
      prev_res  = out_result;
      prev_sel  = out_sel;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one request for one edge; the model records it only if it is accepted.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] sel,
                      output bit acc);
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    acc = in_ready;
    if (acc) exp_q.push_back({sel, alu_f(a, b, sel)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int c = 0;
    while (!out_valid && c < max) begin tick(); c++; end
    if (!out_valid) check({name, "_timeout"}, out_valid, 1);
  endtask

  task automatic drain(input string name);
    int c = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && c < 100) begin tick(); c++; end
    tick();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [DW-1:0] a, b;
    logic [3:0]    sel;
    logic [DW:0]   res;
    logic          carry;
  } vec_t;
  vec_t vecs[10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit acc;
    time t1, t2;
    bit seen;

    vecs[0] = '{8'd255, 8'd0,   4'd0, 9'd255, 1'b0};
    vecs[1] = '{8'd240, 8'd15,  4'd0, 9'd255, 1'b0};
    vecs[2] = '{8'd255, 8'd255, 4'd0, 9'd510, 1'b1};
    vecs[3] = '{8'd128, 8'd128, 4'd0, 9'd256, 1'b1};
    vecs[4] = '{8'd0,   8'd0,   4'd0, 9'd0,   1'b0};
    vecs[5] = '{8'd5,   8'd3,   4'd1, 9'd2,   1'b0};
    vecs[6] = '{8'd3,   8'd5,   4'd1, 9'h1FE, 1'b1};
    vecs[7] = '{8'hF0,  8'h3C,  4'd2, 9'h030, 1'b0};
    vecs[8] = '{8'h0F,  8'hA0,  4'd3, 9'h0AF, 1'b0};
    vecs[9] = '{8'hFF,  8'h0F,  4'd4, 9'h0F0, 1'b0};

    // Reset values while rst_n is low
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_op_count", op_count, 0);

    // Single add: first push right after release, result at push edge +2
    tick();
    rst_n = 1'b1; mon_en = 1'b1; out_ready = 1'b1;
    push(8'd255, 8'd0, 4'd0, acc);
    check("first_push_acc", acc, 1);
    check("lat_edge0", out_valid, 0);
    tick();
    check("lat_edge1", out_valid, 0);
    tick();
    check("lat_edge2", out_valid, 1);
    check("single_result", out_result, 255);
    check("single_carry", out_carry, 0);
    tick();
    check("single_op_count", op_count, 1);

    // Back-to-back pushes, results two cycles apart
    push(8'd240, 8'd15, 4'd0, acc);
    push(8'd255, 8'd255, 4'd0, acc);
    wait_valid("b2b_first", 10);
    t1 = $time;
    check("b2b_first_res", out_result, 255);
    tick();
    wait_valid("b2b_second", 10);
    t2 = $time;
    check("b2b_second_res", out_result, 510);
    check("b2b_second_carry", out_carry, 1);
    check("b2b_spacing", 32'(t2 - t1), 20);
    tick();

    // Table vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].sel, acc);
      tick();
      tick();
      check("vec_valid", out_valid, 1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_sel", out_sel, vecs[i].sel);
      check("vec_carry", out_carry, vecs[i].carry);
      tick();
    end

    // Stall the consumer: one result held, four queued, next push refused
    out_ready = 1'b0;
    push(8'd1, 8'd2, 4'd0, acc);
    wait_valid("stall_first", 10);
    for (int i = 0; i < 4; i++) begin
      push(8'(10 + i), 8'd1, 4'd0, acc);
      check("stall_push_acc", acc, 1);
    end
    check("stall_full_ready", in_ready, 0);
    check("stall_count", dut.u_fifo.count, 4);
    check("stall_result_stable", out_result, 3);

    // Pop and push on the same edge while full: push refused, occupancy drops
    out_ready = 1'b1;
    push(8'd99, 8'd99, 4'd0, acc);
    check("full_push_refused", acc, 0);
    check("full_pop_count", dut.u_fifo.count, 3);
    check("full_pop_ready", in_ready, 1);
    drain("stall");

    // Reset mid-operation with two requests queued
    out_ready = 1'b0;
    push(8'd7, 8'd1, 4'd0, acc);
    push(8'd8, 8'd1, 4'd0, acc);
    push(8'd9, 8'd1, 4'd0, acc);
    wait_valid("midrst", 10);
    check("midrst_count", dut.u_fifo.count, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_sel", out_sel, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_fifo_count", dut.u_fifo.count, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("midrst_no_result", seen, 0);
    push(8'd20, 8'd3, 4'd1, acc);
    wait_valid("postrst", 10);
    check("postrst_result", out_result, 17);
    tick();

    // op_count wrap: preload near the top
    tick();
    force dut.op_count = 16'hFFFE;
    exp_cnt = 32'hFFFE;
    #1;
    release dut.op_count;
    push(8'd1, 8'd1, 4'd0, acc);
    wait_valid("wrap1", 10);
    tick();
    check("wrap_ffff", op_count, 16'hFFFF);
    push(8'd2, 8'd2, 4'd0, acc);
    wait_valid("wrap2", 10);
    tick();
    check("wrap_zero", op_count, 16'h0000);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        push(8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), acc);
      else
        tick();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
